// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_e : FSM state encoding (IDLE, ADD, DONE); code 2'd3 is unused and
//             the FSM treats it as IDLE.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell used by the bit-serial adder.
//   a, b, cin : addend bits and carry-in
//   sum       : a ^ b ^ cin
//   carry     : carry-out
module Full_Adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder. Operands are captured on start, added LSB-first
// one bit per clock through a single Full_Adder and a registered carry, and
// the full word is returned with a one-cycle done pulse.
//   clk         : system clock, rising edge
//   rst         : asynchronous reset, active low
//   start       : begin an addition (only looked at in IDLE)
//   a, b, cin   : operands, captured on the accepting edge
//   busy        : high while bits are being added
//   done        : one-cycle pulse, sum/cout valid from this cycle on
//   sum, cout   : registered result, held until the next completion
//
// state  | meaning
// S_IDLE | waiting for start
// S_ADD  | one operand bit added per edge
// S_DONE | result just written, done pulse
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] ss_q, ss_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] ss_shift;

    Full_Adder u_fa (
        .a     (sa_q[0]),
        .b     (sb_q[0]),
        .cin   (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 lines up.
    assign ss_shift = {fa_sum, ss_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        ss_d    = ss_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    ss_d    = '0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                ss_d    = ss_shift;
                carry_d = fa_carry;
                if (cnt_q == CNT_LAST) begin
                    // Counter is left at its last value so it never wraps.
                    sum_d   = ss_shift;
                    cout_d  = fa_carry;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            ss_q    <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ss_q    <= ss_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == S_ADD);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a8, b8;
    logic       cin8;
    logic [3:0] a4, b4;
    logic       cin4;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

    int n_checks;
    int n_errors;
    int overlap;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst_n),
        .start (start),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst_n),
        .start (start),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ((busy8 && done8) || (busy4 && done4)) overlap = overlap + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish, got timeout, wanted completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept on the next edge, then wait for done8; returns edges after acceptance.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output int lat, output logic [3:0] s4, output logic c4);
        a8 = a; b8 = b; cin8 = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        s4 = '0;
        c4 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            lat = lat + 1;
            if (done4) begin
                s4 = sum4;
                c4 = cout4;
            end
            if (done8) break;
        end
    endtask

    initial begin
        int          lat;
        int          busy_cnt;
        int          done_cnt;
        int          done_cyc[3];
        int          nd;
        logic [3:0]  s4;
        logic        c4;
        logic [8:0]  ref8;
        logic [4:0]  ref4;
        logic [7:0]  ops_a[3];
        logic [7:0]  ops_b[3];
        logic        ops_c[3];
        logic [8:0]  ops_r[3];

        n_checks = 0;
        n_errors = 0;
        overlap  = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0;
        a4 = '0; b4 = '0; cin4 = 1'b0;

        #12;
        chk("rst_sum", 32'(sum8), 32'h0);
        chk("rst_cout", 32'(cout8), 32'h0);
        chk("rst_busy", 32'(busy8), 32'h0);
        chk("rst_done", 32'(done8), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic addition, latency and busy pulse width.
        a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_rise", 32'(busy8), 32'h1);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            lat = lat + 1;
            if (done8) break;
        end
        chk("lat_5a3c", 32'(lat), 32'd8);
        chk("sum_5a3c", 32'(sum8), 32'h96);
        chk("cout_5a3c", 32'(cout8), 32'h0);
        chk("busy_at_done", 32'(busy8), 32'h0);
        tick();
        chk("done_pulse", 32'(done8), 32'h0);

        run8(8'hFF, 8'h01, 1'b0, lat, s4, c4);
        chk("sum_ff01", 32'(sum8), 32'h00);
        chk("cout_ff01", 32'(cout8), 32'h1);
        tick();
        run8(8'hFF, 8'hFF, 1'b1, lat, s4, c4);
        chk("sum_ffff1", 32'(sum8), 32'hFF);
        chk("cout_ffff1", 32'(cout8), 32'h1);
        tick();

        // Start during ADD is ignored; operands may change after acceptance.
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_cnt = busy8 ? 1 : 0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            lat = lat + 1;
            if (lat == 3) begin
                a8 = 8'h77; b8 = 8'h11; cin8 = 1'b1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (busy8) busy_cnt = busy_cnt + 1;
            if (done8) break;
        end
        start = 1'b0;
        chk("ign_lat", 32'(lat), 32'd8);
        chk("ign_sum", 32'(sum8), 32'h30);
        chk("ign_cout", 32'(cout8), 32'h0);
        chk("ign_busy_len", 32'(busy_cnt), 32'd8);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) done_cnt = done_cnt + 1;
        end
        chk("ign_no_extra_done", 32'(done_cnt), 32'd0);

        // start held high: back-to-back at WIDTH+2 cycles.
        ops_a[0] = 8'h12; ops_b[0] = 8'h34; ops_c[0] = 1'b0; ops_r[0] = 9'h046;
        ops_a[1] = 8'h80; ops_b[1] = 8'h80; ops_c[1] = 1'b1; ops_r[1] = 9'h101;
        ops_a[2] = 8'hC3; ops_b[2] = 8'h3D; ops_c[2] = 1'b1; ops_r[2] = 9'h101;
        a8 = ops_a[0]; b8 = ops_b[0]; cin8 = ops_c[0];
        start = 1'b1;
        nd = 0;
        for (int cyc = 0; cyc < 60 && nd < 3; cyc++) begin
            tick();
            if (done8) begin
                done_cyc[nd] = cyc;
                chk($sformatf("b2b_res%0d", nd), 32'({cout8, sum8}), 32'(ops_r[nd]));
                nd = nd + 1;
                if (nd < 3) begin
                    a8 = ops_a[nd]; b8 = ops_b[nd]; cin8 = ops_c[nd];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("b2b_count", 32'(nd), 32'd3);
        if (nd == 3) begin
            chk("b2b_gap0", 32'(done_cyc[1] - done_cyc[0]), 32'd10);
            chk("b2b_gap1", 32'(done_cyc[2] - done_cyc[1]), 32'd10);
        end
        tick();
        tick();

        // Reset in the middle of an addition.
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst_busy", 32'(busy8), 32'h1);
        chk("pre_rst_sum", 32'(sum8), 32'h01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sum", 32'(sum8), 32'h00);
        chk("async_rst_cout", 32'(cout8), 32'h0);
        chk("async_rst_busy", 32'(busy8), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) done_cnt = done_cnt + 1;
            if (busy8) busy_cnt = busy_cnt + 1;
        end
        chk("rst_no_done", 32'(done_cnt), 32'd0);
        chk("rst_idle", 32'(busy_cnt), 32'd0);
        chk("rst_sum_held", 32'(sum8), 32'h00);

        // Random operands on both widths.
        for (int k = 0; k < 200; k++) begin
            logic [7:0] ra, rb;
            logic       rc;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            a4 = 4'($urandom_range(0, 15));
            b4 = 4'($urandom_range(0, 15));
            cin4 = 1'($urandom_range(0, 1));
            ref8 = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
            ref4 = {1'b0, a4} + {1'b0, b4} + {4'b0, cin4};
            run8(ra, rb, rc, lat, s4, c4);
            chk($sformatf("rnd8_%0d", k), 32'({cout8, sum8}), 32'(ref8));
            chk($sformatf("rnd4_%0d", k), 32'({c4, s4}), 32'(ref4));
            tick();
        end

        chk("busy_done_excl", 32'(overlap), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around the existing `Full_Adder` cell. Operands are loaded in parallel on a start request and added LSB-first, one bit per clock, through a single `Full_Adder` plus a registered carry. The block is the sequential stage that consumes the one-bit sum/carry pair each cycle and assembles the full word. It returns a parallel sum and carry-out with a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range ≥ 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `start`  in  1  request to begin an addition; sampled only in IDLE.
- `a`  in  WIDTH  operand A; captured on the accepting edge.
- `b`  in  WIDTH  operand B; captured on the accepting edge.
- `cin`  in  1  carry-in; captured on the accepting edge.
- `busy`  out  1  high while in ADD.
- `done`  out  1  one-cycle pulse; `sum`/`cout` are valid from this cycle on.
- `sum`  out  WIDTH  registered result; holds until the next completion.
- `cout`  out  1  registered carry-out; holds until the next completion.

## Operation
- FSM with three states: IDLE, ADD, DONE.
  - IDLE → ADD on `start`=1.
  - ADD → DONE when the bit counter reaches WIDTH-1.
  - DONE → IDLE unconditionally.
- Accepting edge (IDLE, `start`=1):
  - load shift registers `sa`←`a`, `sb`←`b`;
  - carry flop ← `cin`;
  - counter ← 0;
  - sum shift register `ss` ← 0.
- Each ADD edge:
  - `Full_Adder` inputs are `sa[0]`, `sb[0]`, carry flop;
  - `sa` and `sb` shift right;
  - `ss` shifts right with the FA `sum` entering at bit WIDTH-1;
  - carry flop ← FA `carry`;
  - counter increments.
- Final ADD edge (counter = WIDTH-1): `sum` ← the shifted `ss` value including that edge's bit, and `cout` ← FA `carry`, both written on the same edge.
- Arithmetic rule: `{cout,sum}` = `a` + `b` + `cin`, computed modulo 2^(WIDTH+1).
- `start` in ADD or DONE is ignored. No queuing; a request must be re-presented in IDLE.
- `a`, `b` and `cin` may change freely after the accepting edge without affecting the result.
- Reset (`rst`=0, any time, including mid-ADD):
  - state → IDLE; counter, shift registers and carry flop → 0;
  - `sum`=0, `cout`=0, `busy`=0, `done`=0;
  - a partial addition is discarded and no `done` is produced.

## Timing
- Edge 0 is the accepting edge. `busy` rises after edge 0.
- Edges 1..WIDTH are the ADD edges, one bit per edge. `busy` falls after edge WIDTH.
- `done` is high for exactly the cycle between edges WIDTH and WIDTH+1.
- Latency: from the accepting edge to `done` high is WIDTH edges. Throughput is one addition per WIDTH+2 cycles.
- The earliest re-accept is edge WIDTH+2 (`start` held high continuously yields back-to-back operations at this rate).
- `busy` and `done` are never high together.
- `sum`/`cout` change only on the final ADD edge or on reset.
- Counter width is `$clog2(WIDTH)`; it never wraps during a legal operation.

## Structure
- Shared package:
  - state encoding constants `S_IDLE`=2'd0, `S_ADD`=2'd1, `S_DONE`=2'd2;
  - 2'd3 is unreachable and decodes to IDLE.
- One sub-module instance: `Full_Adder` (ports `a`, `b`, `cin`, `sum`, `carry`), reused unchanged.
- All other logic is in `serial_adder`: FSM, counter, shift registers, carry flop and output registers.

## Test plan
- WIDTH=8, `a`=0x5A, `b`=0x3C, `cin`=0, pulse `start` → `done` 8 edges after acceptance; `sum`=0x96, `cout`=0.
- `a`=0xFF, `b`=0x01, `cin`=0 → `sum`=0x00, `cout`=1. Then `a`=0xFF, `b`=0xFF, `cin`=1 → `sum`=0xFF, `cout`=1.
- Pulse `start` with 0x10+0x20; change `a`/`b` and re-pulse `start` at ADD edge 3 → the second request is ignored; result `sum`=0x30; `busy` stays high exactly 8 cycles.
- Drive `rst`=0 at ADD edge 4 of 0xAA+0x55 → outputs go to 0 immediately (asynchronously); after release, state is IDLE; no `done`; `sum` stays 0x00.
- Hold `start`=1 with a sequence of 3 operand pairs changed after each `done` → 3 `done` pulses spaced 10 cycles apart; each `sum`/`cout` matches `a`+`b`+`cin`.
- Random: 200 random `a`/`b`/`cin` triples at WIDTH=8 and at WIDTH=4 → `{cout,sum}` matches the reference `a`+`b`+`cin`.
